// File: rtl/branch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_pkg                                                                 |
// | Branch funct3 encodings, BHT counter states and taken-decode helpers.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package branch_pkg;

    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    function automatic logic funct3_legal(input logic [2:0] funct3);
        return (funct3 != 3'b010) && (funct3 != 3'b011);
    endfunction

    function automatic logic funct3_taken(input logic [2:0] funct3,
                                          input logic       eq,
                                          input logic       lt);
        logic taken;
        taken = 1'b0;
        case (funct3)
            FUNCT3_BEQ:  taken = eq;
            FUNCT3_BNE:  taken = ~eq;
            FUNCT3_BLT:  taken = lt;
            FUNCT3_BGE:  taken = ~lt;
            FUNCT3_BLTU: taken = lt;
            FUNCT3_BGEU: taken = ~lt;
            default:     taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bht_2bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bht_2bit                                                                   |
// | 2-bit saturating branch history table: async read, sync inc/dec write.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bht_2bit
    import branch_pkg::*;
#(
    parameter int BHT_IDX_BITS = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BHT_IDX_BITS-1:0] rd_idx,
    output bht_state_t              rd_state,
    input  logic                    wr_en,
    input  logic [BHT_IDX_BITS-1:0] wr_idx,
    input  logic                    wr_taken
);

    localparam int c_depth = 2 ** BHT_IDX_BITS;

    bht_state_t r_table [c_depth];
    bht_state_t w_cur;
    bht_state_t w_next;

    // Reads see the stored value, so a same-cycle write is not bypassed.
    assign rd_state = r_table[rd_idx];
    assign w_cur    = r_table[wr_idx];

    always_comb begin
        w_next = w_cur;
        if (wr_taken) begin
            if (w_cur != ST) w_next = bht_state_t'(w_cur + 2'd1);
        end else begin
            if (w_cur != SNT) w_next = bht_state_t'(w_cur - 2'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_depth; i++) r_table[i] <= WNT;
        end else if (wr_en) begin
            r_table[wr_idx] <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_resolve_unit                                                        |
// | EX-stage branch resolution, BHT training, redirect and perf counters.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int BHT_IDX_BITS = 6,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic [2:0]       ex_funct3,
    input  logic             ex_eq,
    input  logic             ex_lt,
    output logic             br_un,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic             r_redirect;
    logic [31:0]      r_redirect_pc;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic       w_fire;
    logic       w_jump;
    logic       w_branch;
    logic       w_legal;
    logic       w_taken;
    logic       w_mispred;
    logic       w_bht_upd;
    bht_state_t w_pred_state;
    logic       w_unused;

    // A jump wins when both type flags are set.
    assign w_jump    = ex_is_jump;
    assign w_branch  = ex_is_branch & ~ex_is_jump;
    assign w_legal   = funct3_legal(ex_funct3);
    assign w_taken   = w_jump | (w_legal & funct3_taken(ex_funct3, ex_eq, ex_lt));
    // The slot behind a redirect is wrong-path and must not resolve.
    assign w_fire    = ex_valid & ~ex_stall & ~r_redirect;
    assign w_mispred = w_fire & (w_jump | (w_branch & w_legal)) & (w_taken != ex_pred_taken);
    assign w_bht_upd = w_fire & w_branch & w_legal;

    assign br_un         = ex_funct3[1];
    assign if_pred_taken = w_pred_state[1];
    assign w_unused      = ^{if_pc[1:0], if_pc[31:BHT_IDX_BITS+2]};

    bht_2bit #(
        .BHT_IDX_BITS(BHT_IDX_BITS)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (if_pc[BHT_IDX_BITS+1:2]),
        .rd_state (w_pred_state),
        .wr_en    (w_bht_upd),
        .wr_idx   (ex_pc[BHT_IDX_BITS+1:2]),
        .wr_taken (w_taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= 32'd0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_redirect <= w_mispred;
            if (w_mispred) begin
                r_redirect_pc <= w_taken ? ex_target : (ex_pc + 32'd4);
                if (r_mispred_cnt != c_cnt_max) r_mispred_cnt <= r_mispred_cnt + 1'b1;
            end
            if (w_bht_upd && (r_branch_cnt != c_cnt_max)) begin
                r_branch_cnt <= r_branch_cnt + 1'b1;
            end
        end
    end

    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_branch_resolve_unit                                                     |
// | Directed scoreboard bench for branch_resolve_unit.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid, ex_stall, ex_is_branch, ex_is_jump;
    logic [2:0]  ex_funct3;
    logic        ex_eq, ex_lt, br_un;
    logic [31:0] ex_pc, ex_target;
    logic        ex_pred_taken;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt, mispred_cnt;

    int          n_checks;
    int          n_fail;
    logic [31:0] r_exp_q [$];

    branch_resolve_unit #(
        .BHT_IDX_BITS(6),
        .CNT_W       (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .ex_valid      (ex_valid),
        .ex_stall      (ex_stall),
        .ex_is_branch  (ex_is_branch),
        .ex_is_jump    (ex_is_jump),
        .ex_funct3     (ex_funct3),
        .ex_eq         (ex_eq),
        .ex_lt         (ex_lt),
        .br_un         (br_un),
        .ex_pc         (ex_pc),
        .ex_target     (ex_target),
        .ex_pred_taken (ex_pred_taken),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Every redirect pulse must match the oldest outstanding expected target.
    always @(negedge clk) begin
        if (!rst && redirect === 1'b1) begin
            if (r_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_redirect: got pc %h, expected no redirect", redirect_pc);
            end else begin
                check("redirect_pc", redirect_pc, r_exp_q.pop_front());
            end
        end
    end

    task automatic idle();
        ex_valid = 1'b0; ex_stall = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
        @(posedge clk); #1;
    endtask

    // Drives one EX slot across one clock edge; returns 1 ns after that edge.
    task automatic issue(input logic stall, input logic br, input logic jmp,
                         input logic [2:0] f3, input logic eq, input logic lt,
                         input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
        ex_valid = 1'b1; ex_stall = stall; ex_is_branch = br; ex_is_jump = jmp;
        ex_funct3 = f3; ex_eq = eq; ex_lt = lt; ex_pc = pc; ex_target = tgt;
        ex_pred_taken = pred;
        @(posedge clk); #1;
    endtask

    task automatic pred_at(input string name, input logic [31:0] pc, input logic exp);
        if_pc = pc; #1;
        check(name, {31'd0, if_pred_taken}, {31'd0, exp});
    endtask

    task automatic counts(input string name, input logic [31:0] b, input logic [31:0] m);
        check({name, "_branch_cnt"}, branch_cnt, b);
        check({name, "_mispred_cnt"}, mispred_cnt, m);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; if_pc = 32'h0;
        ex_valid = 0; ex_stall = 0; ex_is_branch = 0; ex_is_jump = 0;
        ex_funct3 = 3'b000; ex_eq = 0; ex_lt = 0; ex_pc = 0; ex_target = 0; ex_pred_taken = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_redirect", {31'd0, redirect}, 32'd0);
        check("reset_redirect_pc", redirect_pc, 32'd0);
        counts("reset", 0, 0);

        // 1: BEQ taken, predicted not taken
        pred_at("t1_pred_before", 32'h40, 1'b0);
        r_exp_q.push_back(32'h80);
        issue(0, 1, 0, 3'b000, 1, 0, 32'h40, 32'h80, 0);
        check("t1_br_un", {31'd0, br_un}, 32'd0);
        counts("t1", 1, 1);
        idle();
        pred_at("t1_pred_after", 32'h40, 1'b1);

        // 2: BGEU with lt=1 -> not taken, predicted taken
        r_exp_q.push_back(32'h104);
        issue(0, 1, 0, 3'b111, 0, 1, 32'h100, 32'h500, 1);
        check("t2_br_un", {31'd0, br_un}, 32'd1);
        idle();
        counts("t2", 2, 2);

        // 3: saturate to 11, step back to 10, then hold at 00
        for (int i = 0; i < 4; i++) issue(0, 1, 0, 3'b000, 1, 0, 32'h80, 32'h90, 1);
        counts("t3_train", 6, 2);
        pred_at("t3_pred_st", 32'h80, 1'b1);
        r_exp_q.push_back(32'h84);
        issue(0, 1, 0, 3'b000, 0, 0, 32'h80, 32'h90, 1);
        idle();
        pred_at("t3_pred_wt", 32'h80, 1'b1);
        issue(0, 1, 0, 3'b001, 1, 0, 32'h100, 32'h500, 0);
        idle();
        pred_at("t3_pred_snt_hold", 32'h100, 1'b0);
        counts("t3", 8, 3);

        // 4: back-to-back mispredicts; the second is wrong-path
        r_exp_q.push_back(32'hC8);
        issue(0, 1, 0, 3'b000, 1, 0, 32'hC0, 32'hC8, 0);
        issue(0, 1, 0, 3'b000, 1, 0, 32'hD0, 32'hE0, 0);
        idle();
        pred_at("t4_shadow_bht", 32'hD0, 1'b0);
        pred_at("t4_first_bht", 32'hC0, 1'b1);
        counts("t4", 9, 4);

        // 5: JAL mispredict, then illegal funct3
        r_exp_q.push_back(32'h200);
        issue(0, 0, 1, 3'b000, 0, 0, 32'h180, 32'h200, 0);
        idle();
        counts("t5_jal", 9, 5);
        issue(0, 1, 0, 3'b010, 1, 0, 32'h1A0, 32'h300, 1);
        idle();
        counts("t5_illegal", 9, 5);

        // 6: stalled mispredict, then reset while a redirect is pending
        issue(1, 1, 0, 3'b000, 0, 0, 32'h40, 32'h80, 1);
        idle();
        counts("t6_stall", 9, 5);
        pred_at("t6_stall_bht", 32'h40, 1'b1);
        r_exp_q.push_back(32'h300);
        issue(0, 1, 0, 3'b000, 1, 0, 32'h20, 32'h300, 0);
        ex_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_rst_redirect", {31'd0, redirect}, 32'd0);
        check("t6_rst_redirect_pc", redirect_pc, 32'd0);
        counts("t6_rst", 0, 0);
        r_exp_q.delete();
        rst = 1'b0;
        pred_at("t6_bht_reset_wt", 32'h80, 1'b0);
        issue(0, 1, 0, 3'b000, 1, 0, 32'h100, 32'h140, 1);
        idle();
        pred_at("t6_bht_reset_snt", 32'h100, 1'b1);
        counts("t6_after", 1, 0);

        repeat (3) idle();
        check("scoreboard_drained", r_exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 ns, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
